ecc_op_dispatch: RTL

- Front-end controller for the ECC datapath.
- Accepts one instruction plus two 40-bit field operands (5 bytes each) over a valid/ready handshake.
- Issues a one-cycle start pulse to the addressed arithmetic unit (1, 2 or 3) and holds operands stable until that unit reports done.
- Drives the 3-bit select code into the downstream result register for exactly one cycle, then flags completion; guards each operation with a timeout.

---
 rtl/ecc_op_dispatch_pkg.sv | 35 +++
 rtl/ecc_op_dispatch_if.sv | 28 ++
 rtl/ecc_op_dispatch_timeout_cnt.sv | 31 +++
 rtl/ecc_op_dispatch.sv | 112 +++++++++++
 4 files changed

// File: rtl/ecc_op_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module : ecc_ctrl_pkg
// Brief  : Shared widths, instruction codes, dispatch states and start decode
// Rev    : 1.0  initial release
// ============================================================================
package ecc_ctrl_pkg;

    localparam int ELEM_W = 40;

    localparam logic [2:0] INST_NOP = 3'd0;
    localparam logic [2:0] INST_U1  = 3'd1;
    localparam logic [2:0] INST_U2  = 3'd2;
    localparam logic [2:0] INST_U3  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RESP   = 3'd4
    } disp_state_t;

    // Zero result marks an illegal instruction.
    function automatic logic [2:0] inst_onehot(input logic [2:0] inst);
        case (inst)
            INST_U1: return 3'b001;
            INST_U2: return 3'b010;
            INST_U3: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_op_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module : ecc_op_dispatch_if
// Brief  : Request/response handshake between a requester and the dispatcher
// Rev    : 1.0  initial release
// ============================================================================
interface ecc_op_dispatch_if;

    logic                           req_valid;
    logic                           req_ready;
    logic [2:0]                     req_inst;
    logic [ecc_ctrl_pkg::ELEM_W-1:0] req_a;
    logic [ecc_ctrl_pkg::ELEM_W-1:0] req_b;
    logic                           rsp_valid;
    logic                           rsp_err;

    modport master (
        output req_valid, req_inst, req_a, req_b,
        input  req_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  req_valid, req_inst, req_a, req_b,
        output req_ready, rsp_valid, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/ecc_op_dispatch_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : ecc_timeout_cnt
// Brief  : WAIT-cycle counter with terminal count at TIMEOUT-1
// Rev    : 1.0  initial release
// ============================================================================
module ecc_timeout_cnt #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/ecc_op_dispatch.sv
`default_nettype none
// ============================================================================
// Module : ecc_op_dispatch
// Brief  : Dispatches one ECC instruction to unit 1..3, waits for done, commits
// Rev    : 1.0  initial release
// ============================================================================
module ecc_op_dispatch
    import ecc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    ecc_op_dispatch_if.slave       req_if,
    output logic [ELEM_W-1:0]      op_a,
    output logic [ELEM_W-1:0]      op_b,
    output logic [2:0]             start,
    input  wire logic [2:0]        done,
    output logic [2:0]             sel_inst,
    output logic                   busy
);

    disp_state_t r_state;
    logic [2:0]  r_inst;
    logic [2:0]  w_req_oh;
    logic        w_done_hit;
    logic        w_tc;

    assign w_req_oh   = inst_onehot(req_if.req_inst);
    // Only the addressed unit's done is honoured; others are ignored.
    assign w_done_hit = |(done & inst_onehot(r_inst));

    ecc_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_state == ST_ISSUE),
        .enable (r_state == ST_WAIT),
        .tc     (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_inst           <= INST_NOP;
            op_a             <= '0;
            op_b             <= '0;
            start            <= 3'b000;
            sel_inst         <= INST_NOP;
            busy             <= 1'b0;
            req_if.req_ready <= 1'b1;
            req_if.rsp_valid <= 1'b0;
            req_if.rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_if.req_valid) begin
                        r_inst           <= req_if.req_inst;
                        op_a             <= req_if.req_a;
                        op_b             <= req_if.req_b;
                        req_if.req_ready <= 1'b0;
                        busy             <= 1'b1;
                        if (w_req_oh != 3'b000) begin
                            start   <= w_req_oh;
                            r_state <= ST_ISSUE;
                        end else begin
                            req_if.rsp_valid <= 1'b1;
                            req_if.rsp_err   <= 1'b1;
                            r_state          <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    start   <= 3'b000;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a coincident timeout.
                    if (w_done_hit) begin
                        sel_inst <= r_inst;
                        r_state  <= ST_COMMIT;
                    end else if (w_tc) begin
                        req_if.rsp_valid <= 1'b1;
                        req_if.rsp_err   <= 1'b1;
                        r_state          <= ST_RESP;
                    end
                end
                ST_COMMIT: begin
                    sel_inst         <= INST_NOP;
                    req_if.rsp_valid <= 1'b1;
                    req_if.rsp_err   <= 1'b0;
                    r_state          <= ST_RESP;
                end
                ST_RESP: begin
                    req_if.rsp_valid <= 1'b0;
                    req_if.rsp_err   <= 1'b0;
                    req_if.req_ready <= 1'b1;
                    busy             <= 1'b0;
                    r_state          <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
